// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-requester round-robin arbiter/sequencer for a single-port 32x8 RAM
// Optional write protection of the upper address range: define RAM_ARB_WRPROT_EN.
module ram_arbiter #(
    parameter int AW        = 5,
    parameter int DW        = 8,
    parameter int PROT_BASE = 24
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_a,
    input  logic          req_b,
    input  logic          we_a,
    input  logic          we_b,
    input  logic [AW-1:0] addr_a,
    input  logic [AW-1:0] addr_b,
    input  logic [DW-1:0] wdata_a,
    input  logic [DW-1:0] wdata_b,
    output logic          gnt_a,
    output logic          gnt_b,
    output logic          done_a,
    output logic          done_b,
    output logic [DW-1:0] rdata_a,
    output logic [DW-1:0] rdata_b,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_we,
    output logic          ram_re,
    input  logic [DW-1:0] ram_rdata,
`ifdef RAM_ARB_WRPROT_EN
    input  logic          wp_en,
    output logic          err_a,
    output logic          err_b,
`endif
    output logic          ram_rst_n
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ISSUE   = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          last_b_q, last_b_d;
    logic          we_q, we_d;
    logic          gnt_a_q, gnt_a_d, gnt_b_q, gnt_b_d;
    logic          done_a_q, done_a_d, done_b_q, done_b_d;
    logic [DW-1:0] rdata_a_q, rdata_a_d, rdata_b_q, rdata_b_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic [DW-1:0] ram_wdata_q, ram_wdata_d;
    logic          ram_we_q, ram_we_d, ram_re_q, ram_re_d;

    logic          win_b, win_we, prot_hit, wp_active;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_wdata;

    // last_b_q doubles as the owner of the in-flight access
    always_comb begin
        state_d     = state_q;
        last_b_d    = last_b_q;
        we_d        = we_q;
        gnt_a_d     = 1'b0;
        gnt_b_d     = 1'b0;
        done_a_d    = 1'b0;
        done_b_d    = 1'b0;
        rdata_a_d   = rdata_a_q;
        rdata_b_d   = rdata_b_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_we_d    = 1'b0;
        ram_re_d    = 1'b0;

        win_b     = req_b && (!req_a || !last_b_q);
        win_we    = win_b ? we_b : we_a;
        win_addr  = win_b ? addr_b : addr_a;
        win_wdata = win_b ? wdata_b : wdata_a;
        prot_hit  = int'(win_addr) >= PROT_BASE;

        case (state_q)
            IDLE: begin
                if (req_a || req_b) begin
                    state_d     = ISSUE;
                    last_b_d    = win_b;
                    we_d        = win_we;
                    gnt_a_d     = !win_b;
                    gnt_b_d     = win_b;
                    ram_addr_d  = win_addr;
                    ram_wdata_d = win_wdata;
                    ram_we_d    = win_we && !(wp_active && prot_hit);
                    ram_re_d    = !win_we;
                end
            end
            ISSUE: begin
                if (we_q) begin
                    state_d  = IDLE;
                    done_a_d = !last_b_q;
                    done_b_d = last_b_q;
                end else begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                state_d  = IDLE;
                done_a_d = !last_b_q;
                done_b_d = last_b_q;
                if (last_b_q) rdata_b_d = ram_rdata;
                else          rdata_a_d = ram_rdata;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            last_b_q    <= 1'b1;
            we_q        <= 1'b0;
            gnt_a_q     <= 1'b0;
            gnt_b_q     <= 1'b0;
            done_a_q    <= 1'b0;
            done_b_q    <= 1'b0;
            rdata_a_q   <= '0;
            rdata_b_q   <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_we_q    <= 1'b0;
            ram_re_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_b_q    <= last_b_d;
            we_q        <= we_d;
            gnt_a_q     <= gnt_a_d;
            gnt_b_q     <= gnt_b_d;
            done_a_q    <= done_a_d;
            done_b_q    <= done_b_d;
            rdata_a_q   <= rdata_a_d;
            rdata_b_q   <= rdata_b_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_we_q    <= ram_we_d;
            ram_re_q    <= ram_re_d;
        end
    end

`ifdef RAM_ARB_WRPROT_EN
    logic err_a_q, err_a_d, err_b_q, err_b_d, blocked_issue;

    // A write in ISSUE with its enable suppressed is exactly a protected write
    always_comb begin
        blocked_issue = (state_q == ISSUE) && we_q && !ram_we_q;
        err_a_d       = blocked_issue && !last_b_q;
        err_b_d       = blocked_issue && last_b_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_a_q <= 1'b0;
            err_b_q <= 1'b0;
        end else begin
            err_a_q <= err_a_d;
            err_b_q <= err_b_d;
        end
    end

    assign wp_active = wp_en;
    assign err_a     = err_a_q;
    assign err_b     = err_b_q;
`else
    assign wp_active = 1'b0;
`endif

    assign gnt_a     = gnt_a_q;
    assign gnt_b     = gnt_b_q;
    assign done_a    = done_a_q;
    assign done_b    = done_b_q;
    assign rdata_a   = rdata_a_q;
    assign rdata_b   = rdata_b_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_we    = ram_we_q;
    assign ram_re    = ram_re_q;
    assign ram_rst_n = ~reset;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - scoreboard bench for ram_arbiter: directed scenarios plus random two-requester traffic
module tb_ram_arbiter;
    localparam int AW = 5;
    localparam int DW = 8;
    localparam int PROT_BASE = 24;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic req_a = 1'b0, req_b = 1'b0, we_a = 1'b0, we_b = 1'b0;
    logic [AW-1:0] addr_a = '0, addr_b = '0;
    logic [DW-1:0] wdata_a = '0, wdata_b = '0;
    logic gnt_a, gnt_b, done_a, done_b, ram_we, ram_re, ram_rst_n;
    logic [DW-1:0] rdata_a, rdata_b, ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic [AW-1:0] ram_addr;
`ifdef RAM_ARB_WRPROT_EN
    logic wp_en = 1'b0;
    logic err_a, err_b;
`endif

    always #5 clk = ~clk;

    ram_arbiter #(.AW(AW), .DW(DW), .PROT_BASE(PROT_BASE)) dut (
        .clk(clk), .reset(reset),
        .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
        .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .done_a(done_a), .done_b(done_b),
        .rdata_a(rdata_a), .rdata_b(rdata_b),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_re(ram_re),
        .ram_rdata(ram_rdata),
`ifdef RAM_ARB_WRPROT_EN
        .wp_en(wp_en), .err_a(err_a), .err_b(err_b),
`endif
        .ram_rst_n(ram_rst_n)
    );

    // Single-port RAM: registered read, sync active-low reset of the output only
    logic [DW-1:0] ram_mem [32];
    always @(posedge clk) begin
        if (!ram_rst_n) ram_rdata <= '0;
        else if (ram_we && !ram_re) ram_mem[ram_addr] <= ram_wdata;
        else if (ram_re && !ram_we) ram_rdata <= ram_mem[ram_addr];
    end

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    typedef struct {
        bit b;
        bit we;
        bit err;
        logic [7:0] data;
        int due;
    } exp_t;

    exp_t exp_q[$];
    logic [7:0] mdl_mem [32];
    bit last_b = 1'b1;
    int free_cyc = 0;
    bit e_gnt_a, e_gnt_b, e_we, e_re;
    logic [4:0] e_addr;
    logic [7:0] e_wdata;
    int gnt_a_cnt = 0;

    // Reference model: arbitration decided from the request pins and the
    // documented latencies (write busy 2 cycles from sample, read busy 3).
    always @(posedge clk) begin
        int c;
        bit pick_b, w, blk;
        logic [4:0] a;
        logic [7:0] d;
        exp_t e;
        c = cyc;
        cyc = cyc + 1;
        e_gnt_a = 0; e_gnt_b = 0; e_we = 0; e_re = 0;
        if (reset) begin
            last_b = 1'b1;
            free_cyc = 0;
        end else if (c >= free_cyc && (req_a || req_b)) begin
            pick_b = (req_a && req_b) ? !last_b : req_b;
            last_b = pick_b;
            w = pick_b ? we_b : we_a;
            a = pick_b ? addr_b : addr_a;
            d = pick_b ? wdata_b : wdata_a;
            blk = 1'b0;
`ifdef RAM_ARB_WRPROT_EN
            blk = wp_en && w && (int'(a) >= PROT_BASE);
`endif
            e_gnt_a = !pick_b;
            e_gnt_b = pick_b;
            e_addr = a;
            e_wdata = d;
            e.b = pick_b; e.we = w; e.err = blk; e.data = '0;
            if (w) begin
                if (!blk) mdl_mem[a] = d;
                e_we = !blk;
                e.due = c + 2;
                free_cyc = c + 2;
            end else begin
                e_re = 1'b1;
                e.data = mdl_mem[a];
                e.due = c + 3;
                free_cyc = c + 3;
            end
            exp_q.push_back(e);
        end
    end

    logic [7:0] exp_rdata_a = '0, exp_rdata_b = '0;
    exp_t me;

    always @(negedge clk) begin
        bit exp_err_a, exp_err_b;
        exp_err_a = 0; exp_err_b = 0;
        if (reset) begin
            chk("reset_outputs_zero", 32'(|{gnt_a, gnt_b, done_a, done_b, ram_we, ram_re,
                                          rdata_a, rdata_b, ram_addr, ram_wdata}), 0);
            chk("reset_ram_rst_n", 32'(ram_rst_n), 0);
            exp_q.delete();
            exp_rdata_a = '0;
            exp_rdata_b = '0;
        end else begin
            if (gnt_a) gnt_a_cnt++;
            chk("gnt_a", 32'(gnt_a), 32'(e_gnt_a));
            chk("gnt_b", 32'(gnt_b), 32'(e_gnt_b));
            chk("ram_we", 32'(ram_we), 32'(e_we));
            chk("ram_re", 32'(ram_re), 32'(e_re));
            chk("ram_rst_n", 32'(ram_rst_n), 1);
            if (e_we || e_re) chk("ram_addr", 32'(ram_addr), 32'(e_addr));
            if (e_we) chk("ram_wdata", 32'(ram_wdata), 32'(e_wdata));
            while (exp_q.size() != 0 && exp_q[0].due < cyc) begin
                chk("missed_done", 0, 1);
                void'(exp_q.pop_front());
            end
            if (done_a || done_b) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'({done_a, done_b}), 0);
                end else begin
                    me = exp_q.pop_front();
                    chk("done_owner", 32'({done_a, done_b}), me.b ? 2'b01 : 2'b10);
                    chk("done_cycle", 32'(cyc), 32'(me.due));
                    if (!me.we) begin
                        if (me.b) exp_rdata_b = me.data;
                        else      exp_rdata_a = me.data;
                    end
                    exp_err_a = me.err && !me.b;
                    exp_err_b = me.err && me.b;
                end
            end
`ifdef RAM_ARB_WRPROT_EN
            chk("err_a", 32'(err_a), 32'(exp_err_a));
            chk("err_b", 32'(err_b), 32'(exp_err_b));
`endif
            chk("rdata_a", 32'(rdata_a), 32'(exp_rdata_a));
            chk("rdata_b", 32'(rdata_b), 32'(exp_rdata_b));
        end
    end

    // Present a command at a negedge and hold it until the grant is seen.
    task automatic issue(input bit b, input bit w, input logic [4:0] a, input logic [7:0] d,
                         output int waited);
        waited = 0;
        if (b) begin req_b = 1; we_b = w; addr_b = a; wdata_b = d; end
        else   begin req_a = 1; we_a = w; addr_a = a; wdata_a = d; end
        forever begin
            @(negedge clk);
            waited++;
            if (b ? gnt_b : gnt_a) break;
            if (waited > 40) begin
                chk("gnt_timeout", 32'(waited), 0);
                break;
            end
        end
        if (b) req_b = 0; else req_a = 0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(exp_q.size()), 0);
        @(negedge clk);
    endtask

    initial begin
        int wt, wt_a, wt_b, g0;
        for (int i = 0; i < 32; i++) begin
            ram_mem[i] = '0;
            mdl_mem[i] = '0;
        end
        repeat (3) @(negedge clk);
        reset = 0;

        // write then read back from A
        issue(0, 1, 5'd5, 8'h3C, wt);
        chk("first_gnt_latency", 32'(wt), 1);
        issue(0, 0, 5'd5, 8'h00, wt);
        wait_idle();
        chk("readback_a_5", 32'(rdata_a), 32'h3C);

        // both requesters held with reads: grants must alternate
        issue(0, 1, 5'd1, 8'h11, wt);
        issue(1, 1, 5'd2, 8'h22, wt);
        fork
            begin for (int i = 0; i < 4; i++) issue(0, 0, 5'd1, 8'h00, wt_a); end
            begin for (int i = 0; i < 4; i++) issue(1, 0, 5'd2, 8'h00, wt_b); end
        join
        wait_idle();
        chk("alt_rdata_a", 32'(rdata_a), 32'h11);
        chk("alt_rdata_b", 32'(rdata_b), 32'h22);

        // back-to-back writes from B at both address extremes
        issue(1, 1, 5'd31, 8'hFF, wt);
        issue(1, 1, 5'd0, 8'h00, wt);
        chk("b2b_write_gnt_gap", 32'(wt), 2);
        issue(1, 0, 5'd31, 8'h00, wt);
        wait_idle();
        chk("readback_b_31", 32'(rdata_b), 32'hFF);
        issue(1, 0, 5'd0, 8'h00, wt);
        wait_idle();
        chk("readback_b_0", 32'(rdata_b), 32'h00);

        // reset during CAPTURE of an A read
        issue(0, 1, 5'd7, 8'h5A, wt);
        issue(0, 0, 5'd7, 8'h00, wt);
        @(negedge clk);
        #2 reset = 1;
        #1;
        chk("async_reset_clear", 32'(|{gnt_a, gnt_b, done_a, done_b, ram_we, ram_re, rdata_a, rdata_b}), 0);
        chk("async_reset_rst_n", 32'(ram_rst_n), 0);
        repeat (2) @(negedge clk);
        reset = 0;
        issue(1, 0, 5'd7, 8'h00, wt);
        chk("post_reset_gnt_latency", 32'(wt), 1);
        wait_idle();
        chk("post_reset_rdata_a", 32'(rdata_a), 0);
        chk("post_reset_rdata_b", 32'(rdata_b), 32'h5A);

        // A raises and withdraws while B owns the RAM
        issue(1, 0, 5'd3, 8'h00, wt);
        g0 = gnt_a_cnt;
        req_a = 1; we_a = 1; addr_a = 5'd9; wdata_a = 8'h77;
        @(negedge clk);
        req_a = 0;
        repeat (4) @(negedge clk);
        chk("withdraw_no_gnt_a", 32'(gnt_a_cnt - g0), 0);
        issue(0, 0, 5'd9, 8'h00, wt);
        wait_idle();
        chk("withdraw_no_write", 32'(rdata_a), 0);

`ifdef RAM_ARB_WRPROT_EN
        wp_en = 1;
        issue(0, 1, 5'd24, 8'hAA, wt);
        issue(0, 0, 5'd24, 8'h00, wt);
        issue(0, 1, 5'd23, 8'h5C, wt);
        issue(0, 0, 5'd23, 8'h00, wt);
        wait_idle();
        chk("wp_unprotected_store", 32'(rdata_a), 32'h5C);
        wp_en = 0;
`endif

        // random traffic from both sides
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    issue(0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                          8'($urandom_range(0, 255)), wt_a);
                end
            end
            begin
                for (int i = 0; i < 30; i++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    issue(1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                          8'($urandom_range(0, 255)), wt_b);
                end
            end
        join
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
        $fatal(1);
    end
endmodule
